// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing RAM port B; each grant owns the port for a whole burst.
// Define MEM_ARB_PERF_EN to add busy-cycle and completed-burst counters.
module mem_port_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 8,
    parameter int ADDR_STEP = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*LEN_W-1:0]  len_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [LEN_W-1:0]          beat_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      busy_o,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]               perf_busy_cnt_o,
    output logic [31:0]               perf_burst_cnt_o,
`endif
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_din_o,
    input  logic [DATA_W-1:0]         mem_dout_i
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    cand_idx;
    int                  cand;
    logic                last_beat;

    // Search starts just after the last owner, so a waiting requester is
    // reached within NUM_REQ-1 bursts.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_q) + 1 + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_found && req_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign last_beat = (beat_q == len_q);

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        len_d    = len_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        we_d     = we_q;
        rvalid_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    rr_d    = pick_idx;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    len_d   = len_i[pick_idx*LEN_W +: LEN_W];
                    addr_d  = addr_i[pick_idx*ADDR_W +: ADDR_W];
                    we_d    = we_i[pick_idx];
                    beat_d  = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (!we_q) rvalid_d = gnt_q;
                if (last_beat) begin
                    state_d = we_q ? S_IDLE : S_DRAIN;
                    if (we_q) gnt_d = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                    addr_d = addr_q + ADDR_W'(ADDR_STEP);
                end
            end
            S_DRAIN: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            rr_q     <= IDX_W'(NUM_REQ - 1);
            gnt_q    <= '0;
            rvalid_q <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign beat_o     = beat_q;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = mem_dout_i;
    assign busy_o     = (state_q != S_IDLE);
    assign mem_we_o   = (state_q == S_BURST) && we_q;
    assign mem_addr_o = addr_q;
    assign mem_din_o  = mem_we_o ? wdata_i[rr_q*DATA_W +: DATA_W] : '0;
    assign done_o     = (((state_q == S_BURST) && we_q && last_beat) ||
                         (state_q == S_DRAIN)) ? gnt_q : '0;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_busy_cnt_q, perf_busy_cnt_d;
    logic [31:0] perf_burst_cnt_q, perf_burst_cnt_d;

    always_comb begin
        perf_busy_cnt_d  = perf_busy_cnt_q + 32'(busy_o);
        perf_burst_cnt_d = perf_burst_cnt_q + 32'(|done_o);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            perf_busy_cnt_q  <= '0;
            perf_burst_cnt_q <= '0;
        end else begin
            perf_busy_cnt_q  <= perf_busy_cnt_d;
            perf_burst_cnt_q <= perf_burst_cnt_d;
        end
    end

    assign perf_busy_cnt_o  = perf_busy_cnt_q;
    assign perf_burst_cnt_o = perf_burst_cnt_q;
`endif

endmodule
